// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains a first-word-fall-through FIFO and sends each popped word
//            as an 8-N-1 style UART frame with an internal baud-tick source.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 651,
    parameter int DVSR_W  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy
);
    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DVSR_W-1:0] c_b_max      = DVSR_W'(DVSR - 1);
    localparam logic [DVSR_W-1:0] c_b_one      = DVSR_W'(1);
    localparam logic [S_W-1:0]    c_s_bit_end  = S_W'(15);
    localparam logic [S_W-1:0]    c_s_stop_end = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0]    c_s_one      = S_W'(1);
    localparam logic [N_W-1:0]    c_n_last     = N_W'(DBIT - 1);
    localparam logic [N_W-1:0]    c_n_one      = N_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DVSR_W-1:0] r_b_cnt, w_b_cnt_nxt;
    logic [S_W-1:0]    r_s_cnt, w_s_cnt_nxt;
    logic [N_W-1:0]    r_n_cnt, w_n_cnt_nxt;
    logic [DBIT-1:0]   r_b_reg, w_b_reg_nxt;
    logic              r_tx, w_tx_nxt;
    logic              w_s_tick;
    logic [DBIT-1:0]   w_b_shift;

    assign w_s_tick  = (r_b_cnt == c_b_max);
    assign w_b_shift = r_b_reg >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_b_cnt <= '0;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_b_reg <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_b_cnt <= w_b_cnt_nxt;
            r_s_cnt <= w_s_cnt_nxt;
            r_n_cnt <= w_n_cnt_nxt;
            r_b_reg <= w_b_reg_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_b_cnt_nxt = w_s_tick ? '0 : (r_b_cnt + c_b_one);
        w_s_cnt_nxt = r_s_cnt;
        w_n_cnt_nxt = r_n_cnt;
        w_b_reg_nxt = r_b_reg;
        w_tx_nxt    = r_tx;
        rd          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Baud phase held at zero so every frame starts on a fresh tick period
                w_b_cnt_nxt = '0;
                w_tx_nxt    = 1'b1;
                if (!empty) begin
                    rd          = 1'b1;
                    w_b_reg_nxt = r_data;
                    w_s_cnt_nxt = '0;
                    w_n_cnt_nxt = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_s_bit_end) begin
                        w_s_cnt_nxt = '0;
                        w_tx_nxt    = r_b_reg[0];
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + c_s_one;
                    end
                end
            end
            ST_DATA: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_s_bit_end) begin
                        w_s_cnt_nxt = '0;
                        w_b_reg_nxt = w_b_shift;
                        if (r_n_cnt == c_n_last) begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_n_cnt_nxt = r_n_cnt + c_n_one;
                            w_tx_nxt    = w_b_shift[0];
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + c_s_one;
                    end
                end
            end
            ST_STOP: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_s_stop_end) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + c_s_one;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed self-checking bench for fifo_uart_tx with a small FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;
    logic       clk;
    logic       reset;
    logic       empty;
    logic [7:0] r_data;
    logic       rd;
    logic       tx;
    logic       tx_busy;

    int errors   = 0;
    int checks   = 0;
    int rd_count = 0;

    // First-word-fall-through FIFO model driving empty/r_data
    logic [7:0] mem [0:15];
    int head  = 0;
    int count = 0;

    fifo_uart_tx #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR    (2),
        .DVSR_W  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .empty   (empty),
        .r_data  (r_data),
        .rd      (rd),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_in();
        empty  = (count == 0);
        r_data = mem[head % 16];
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[(head + count) % 16] = w;
        count++;
        update_in();
    endtask

    task automatic drop();
        if (count > 0) count--;
        update_in();
    endtask

    // One clock; the FIFO pops if rd was high going into the edge
    task automatic tick();
        logic rd_pre;
        rd_pre = rd;
        @(posedge clk);
        #1;
        if (rd_pre === 1'b1) begin
            rd_count++;
            if (count > 0) begin
                head++;
                count--;
            end
        end
        update_in();
    endtask

    // Called right after the edge that ends the rd cycle; returns 320 cycles later
    task automatic frame(input logic [7:0] w, input string tag, input bit toggle);
        logic [9:0] bits;
        logic       ok;
        bits = {1'b1, w, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ok = 1'b1;
            for (int c = 0; c < 32; c++) begin
                if (tx !== bits[i] || tx_busy !== 1'b1 || rd !== 1'b0) ok = 1'b0;
                if (toggle && c == 16) begin
                    if (count == 0) push(8'h96);
                    else drop();
                end
                tick();
            end
            chk($sformatf("%s bit%0d", tag, i), {31'd0, ok}, 32'd1);
        end
    endtask

    task automatic idle_hold(input string tag, input int n);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (tx !== 1'b1 || rd !== 1'b0 || tx_busy !== 1'b0) ok = 1'b0;
            tick();
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        empty  = 1'b1;
        r_data = 8'h00;
        #1;
        chk("reset tx async", {31'd0, tx}, 32'd1);
        chk("reset busy async", {31'd0, tx_busy}, 32'd0);
        chk("reset rd", {31'd0, rd}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        idle_hold("reset hold 100", 100);

        // Single word 0xA5
        push(8'hA5);
        chk("single rd same cycle", {31'd0, rd}, 32'd1);
        chk("single tx before start", {31'd0, tx}, 32'd1);
        chk("single busy before start", {31'd0, tx_busy}, 32'd0);
        tick();
        frame(8'hA5, "single", 1'b0);
        chk("single busy end", {31'd0, tx_busy}, 32'd0);
        idle_hold("single idle after", 40);
        chk("single rd pulses", rd_count, 32'd1);

        // Back-to-back 0x00, 0xFF, 0x3C
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        chk("b2b rd0", {31'd0, rd}, 32'd1);
        tick();
        frame(8'h00, "b2b f0", 1'b0);
        chk("b2b rd1", {31'd0, rd}, 32'd1);
        chk("b2b gap tx", {31'd0, tx}, 32'd1);
        tick();
        frame(8'hFF, "b2b f1", 1'b0);
        chk("b2b rd2", {31'd0, rd}, 32'd1);
        tick();
        frame(8'h3C, "b2b f2", 1'b0);
        idle_hold("b2b idle after", 20);
        chk("b2b rd pulses", rd_count, 32'd4);

        // Reset during data bit 4 of 0x55
        push(8'h55);
        tick();
        for (int k = 0; k < 32 * 5 + 10; k++) tick();
        chk("midrst tx bit4", {31'd0, tx}, 32'd1);
        chk("midrst busy before", {31'd0, tx_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst busy async", {31'd0, tx_busy}, 32'd0);
        chk("midrst tx async", {31'd0, tx}, 32'd1);
        chk("midrst rd", {31'd0, rd}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        idle_hold("midrst hold 100", 100);
        chk("midrst rd pulses", rd_count, 32'd5);

        // Empty toggling during a frame of 0xC3
        push(8'hC3);
        tick();
        frame(8'hC3, "toggle", 1'b1);
        idle_hold("toggle idle after", 20);
        chk("toggle rd pulses", rd_count, 32'd6);

        // Producer writes four words while the first one is being sent
        push(8'h12);
        tick();
        push(8'h34);
        push(8'h56);
        push(8'h78);
        frame(8'h12, "integ w0", 1'b0);
        chk("integ rd1", {31'd0, rd}, 32'd1);
        tick();
        frame(8'h34, "integ w1", 1'b0);
        chk("integ rd2", {31'd0, rd}, 32'd1);
        tick();
        frame(8'h56, "integ w2", 1'b0);
        chk("integ rd3", {31'd0, rd}, 32'd1);
        tick();
        frame(8'h78, "integ w3", 1'b0);
        idle_hold("integ idle after", 20);
        chk("integ rd pulses", rd_count, 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's `fifo` block. It drains the FIFO by popping one word whenever the FIFO is non-empty and the serializer is idle, then sends that word on an asynchronous serial line as 8-N-1 style UART framing. It has an internal baud-tick generator. It pairs with the button/switch-driven write path: the producer fills the FIFO, and this block empties it onto `tx`.

## Interface
- `DBIT`, 8: data bits per frame, sent LSB first.
- `SB_TICK`, 16: stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `DVSR`, 651: clock cycles per oversample tick. 100 MHz / (16 × 9600) ≈ 651.
- `DVSR_W`, 10: width of the baud counter. Must satisfy 2^DVSR_W ≥ DVSR.

- `clk` in, 1: single system clock. All state changes on the rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `empty` in, 1: FIFO empty flag.
- `r_data` in, DBIT: FIFO head word. Valid whenever `empty`=0 (first-word fall-through, as `fifo` provides).
- `rd` out, 1: FIFO pop strobe, one cycle wide.
- `tx` out, 1: serial output, registered, idle high.
- `tx_busy` out, 1: high from the frame start until the return to idle.

## Operation
- **Baud generator.** `b_cnt` counts 0..DVSR-1 and wraps. `s_tick` = (`b_cnt` == DVSR-1). `b_cnt` is forced to 0 in idle, so every frame starts at tick phase 0.
- **Oversample counter.** `s_cnt` (4 bits, or wide enough for SB_TICK-1) counts ticks within the current bit.
- **Bit counter.** `n_cnt` counts data bits sent. Shift register `b_reg` is DBIT wide.
- **States** (reset → IDLE):
  - IDLE: `rd` = ~`empty` (combinational, Moore-on-state plus `empty`). If `empty`=0: load `b_reg` ← `r_data`, clear `s_cnt`, `n_cnt` and `b_cnt`, set `tx` ← 0, go to START. Otherwise hold, with `tx`=1.
  - START: `tx`=0. On `s_tick` with `s_cnt`=15: set `s_cnt` ← 0, `tx` ← `b_reg[0]`, go to DATA. On any other `s_tick`: `s_cnt`++.
  - DATA: `tx`=`b_reg[0]`. On `s_tick` with `s_cnt`=15: shift `b_reg` right and set `s_cnt` ← 0.
    - If `n_cnt`=DBIT-1: `tx` ← 1, go to STOP.
    - Else: `n_cnt`++, `tx` ← next bit.
  - STOP: `tx`=1. On `s_tick` with `s_cnt`=SB_TICK-1, go to IDLE.
- `tx_busy` = 1 in START, DATA and STOP.
- **Pop rules.** `rd` is never high while `empty`=1 or outside IDLE. Exactly one pop per frame. Changes on `empty` or `r_data` outside IDLE are ignored.
- **Reset mid-frame.** The frame is abandoned and `tx` returns high immediately. A word that was already popped is lost; no re-read occurs.

## Timing
- Reset values: `tx`=1, `rd`=0, `tx_busy`=0, state IDLE, all counters 0.
- Pop latency:
  - `rd` goes high in the same cycle `empty` falls while the block is IDLE.
  - `tx` falls at the edge that ends the `rd` cycle.
  - `tx_busy` rises at that same edge.
- Bit period is exactly 16·DVSR clocks for the start bit and each data bit. The stop bit is SB_TICK·DVSR clocks.
- Frame length, from the `tx` fall to the return to IDLE: (1+DBIT)·16·DVSR + SB_TICK·DVSR clocks.
- Back-to-back frames (FIFO still non-empty): one IDLE cycle separates the frames. The stop bit therefore lasts SB_TICK·DVSR + 1 clocks.
- Empty FIFO: the block stays in IDLE indefinitely with `tx`=1 and no `rd` pulses.

## Test plan
1. **Reset.** Assert `reset` with `empty`=1 → `tx`=1, `rd`=0, `tx_busy`=0. Hold 100 cycles → no change.
2. **Single word** (DVSR=2, DBIT=8, SB_TICK=16), `r_data`=8'hA5, `empty` falls for one cycle:
   - Exactly one `rd` pulse.
   - `tx` shows 0 (start), then bits 1,0,1,0,0,1,0,1, then 1. Each bit lasts 32 cycles; the stop bit lasts 32 cycles.
   - `tx_busy` is high for exactly 320 cycles.
3. **Back-to-back.** FIFO preloaded with 8'h00, 8'hFF, 8'h3C:
   - Three `rd` pulses, 321 cycles apart.
   - Frames appear in order with a 33-cycle stop bit between frames.
   - `rd` is never asserted after `empty` rises.
4. **Mid-frame reset.** Assert `reset` during DATA bit 4 of 8'h55 → `tx`=1 and `tx_busy`=0 asynchronously. After release with `empty`=1: no `rd` and no further frame.
5. **Empty toggling.** Toggle `empty` during a frame → no `rd` until STOP completes. The frame's bit timing is unchanged.
6. **Integration.** `fifo` (B=8, W=2) plus this block: write 4 words via `wr` → FIFO reaches full, then drains. `empty`=1 after the 4th `rd`. The serial decode of `tx` equals the write order.
